// File: rtl/rx_comma_aligner_if.sv
// Serial-in / aligned-word-out bundle for the comma aligner.
// The aligner side uses the master modport; the PHY/consumer side uses slave.
interface rx_comma_aligner_if;
    logic       serial_in;
    logic [9:0] word_out;
    logic       word_valid;
    logic       is_comma;
    logic       locked;
    logic [7:0] realign_cnt;

    modport master (
        input  serial_in,
        output word_out, word_valid, is_comma, locked, realign_cnt
    );
    modport slave (
        output serial_in,
        input  word_out, word_valid, is_comma, locked, realign_cnt
    );
endinterface

// File: rtl/rx_comma_aligner.sv
// Serial 8b/10b comma aligner: hunts for K28.5, confirms the symbol boundary with
// LOCK_COMMAS aligned commas, then emits one 10-bit word per symbol.
module rx_comma_aligner #(
    parameter int LOCK_COMMAS = 3,
    parameter int UNLOCK_MISS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rx_comma_aligner_if.master bus
);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    // Window holds bit a at [0] up to bit j at [9], so the patterns read j..a here.
    localparam logic [9:0] K28_5_NEG = 10'b0101111100;
    localparam logic [9:0] K28_5_POS = 10'b1010000011;
    localparam logic [3:0] LOCK_N    = 4'(LOCK_COMMAS);
    localparam logic [3:0] MISS_N    = 4'(UNLOCK_MISS);

    logic [9:0] window;
    logic [3:0] slot, good_cnt, miss_cnt;
    logic [3:0] good_nx, miss_nx, good_inc, miss_inc;
    logic [1:0] state, state_nx;
    logic       comma, aligned, realign, emit;
    logic [9:0] word_q;
    logic       valid_q, comma_q, locked_q;
    logic [7:0] realign_q;

    assign comma    = (window == K28_5_NEG) || (window == K28_5_POS);
    assign aligned  = (slot == 4'd9);
    assign good_inc = good_cnt + 4'd1;
    assign miss_inc = miss_cnt + 4'd1;

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        miss_nx  = miss_cnt;
        realign  = 1'b0;
        case (state)
            SEARCH: if (comma) realign = 1'b1;
            CHECK: if (comma) begin
                if (aligned) begin
                    good_nx = good_inc;
                    if (good_inc == LOCK_N) state_nx = LOCKED;
                end else begin
                    realign = 1'b1;
                end
            end
            LOCKED: if (comma) begin
                if (aligned) begin
                    miss_nx = 4'd0;
                end else if (miss_inc == MISS_N) begin
                    miss_nx  = 4'd0;
                    state_nx = SEARCH;
                end else begin
                    miss_nx = miss_inc;
                end
            end
            default: state_nx = SEARCH;
        endcase
        if (realign) begin
            good_nx  = 4'd1;
            state_nx = (LOCK_N == 4'd1) ? LOCKED : CHECK;
        end
    end

    // A realigning comma is itself the first word of the new boundary.
    assign emit = realign || ((state != SEARCH) && aligned);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window    <= '0;
            slot      <= '0;
            state     <= SEARCH;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            comma_q   <= 1'b0;
            locked_q  <= 1'b0;
            realign_q <= '0;
        end else begin
            window   <= {bus.serial_in, window[9:1]};
            slot     <= (realign || aligned) ? 4'd0 : slot + 4'd1;
            state    <= state_nx;
            good_cnt <= good_nx;
            miss_cnt <= miss_nx;
            valid_q  <= emit;
            locked_q <= (state_nx == LOCKED);
            if (emit) begin
                word_q  <= window;
                comma_q <= comma;
            end
            if (realign && (realign_q != 8'hFF)) realign_q <= realign_q + 8'd1;
        end
    end

    assign bus.word_out    = word_q;
    assign bus.word_valid  = valid_q;
    assign bus.is_comma    = comma_q;
    assign bus.locked      = locked_q;
    assign bus.realign_cnt = realign_q;
endmodule

// File: tb/tb_rx_comma_aligner.sv
// Bench for rx_comma_aligner: directed phases plus random traffic, each output
// compared every cycle with a bit-history model of the aligner.
module tb_rx_comma_aligner;
    localparam int LOCK_COMMAS = 3;
    localparam int UNLOCK_MISS = 4;
    localparam bit [0:9] K28N = 10'b0011111010;
    localparam bit [0:9] K28P = 10'b1100000101;
    localparam bit [0:9] D215 = 10'b1010101010;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rx_comma_aligner_if bus ();
    rx_comma_aligner #(.LOCK_COMMAS(LOCK_COMMAS), .UNLOCK_MISS(UNLOCK_MISS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: the full bit history since reset; alignment is the absolute index
    // of the bit that completed the last realigning comma.
    bit         hist[$];
    int         mstate, good, miss, align_end, rc;
    logic [9:0] m_word;
    logic       m_comma, m_valid, m_locked;

    int   step_n, first_valid, lock_rise, last_valid, max_gap, valid_cnt, unlock_cycles;
    logic prev_locked;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 10; i++) hist.push_back(1'b0);
        mstate = 0; good = 0; miss = 0; align_end = 0; rc = 0;
        m_word = '0; m_comma = 1'b0; m_valid = 1'b0; m_locked = 1'b0;
    endfunction

    // Decide the next-edge outputs from the bits seen so far, then record b.
    function automatic void model_step(input bit b);
        int         n    = hist.size();
        int         idx  = n - 1;
        int         prev = mstate;
        logic [9:0] w;
        bit         kn = 1'b1, kp = 1'b1, comma, aligned, realign = 1'b0, emit;
        for (int i = 0; i < 10; i++) begin
            w[i] = hist[n - 10 + i];
            if (w[i] != K28N[i]) kn = 1'b0;
            if (w[i] != K28P[i]) kp = 1'b0;
        end
        comma   = kn | kp;
        aligned = ((idx - align_end) % 10) == 0;
        if (comma) begin
            if (mstate == 0) realign = 1'b1;
            else if (mstate == 1) begin
                if (aligned) begin
                    good++;
                    if (good == LOCK_COMMAS) mstate = 2;
                end else realign = 1'b1;
            end else begin
                if (aligned) miss = 0;
                else begin
                    miss++;
                    if (miss == UNLOCK_MISS) begin miss = 0; mstate = 0; end
                end
            end
        end
        if (realign) begin
            align_end = idx;
            good      = 1;
            if (rc < 255) rc++;
            mstate    = (LOCK_COMMAS == 1) ? 2 : 1;
        end
        emit = realign || (prev != 0 && aligned);
        if (emit) begin m_word = w; m_comma = comma; end
        m_valid  = emit;
        m_locked = (mstate == 2);
        hist.push_back(b);
    endfunction

    task automatic send_bit(input bit b);
        logic [20:0] obs_v, exp_v;
        @(negedge clk);
        bus.serial_in = b;
        model_step(b);
        @(posedge clk);
        #1;
        step_n++;
        obs_v = {bus.word_out, bus.is_comma, bus.word_valid, bus.locked, bus.realign_cnt};
        exp_v = {m_word, m_comma, m_valid, m_locked, 8'(rc)};
        check("cycle_outputs", 32'(obs_v), 32'(exp_v));
        if (bus.word_valid) begin
            if (first_valid == 0) first_valid = step_n;
            if (step_n - last_valid > max_gap) max_gap = step_n - last_valid;
            last_valid = step_n;
            valid_cnt++;
        end
        if (bus.locked && !prev_locked && lock_rise == 0) lock_rise = step_n;
        if (!bus.locked) unlock_cycles++;
        prev_locked = bus.locked;
    endtask

    task automatic send_sym(input bit [0:9] s, input int len);
        for (int i = 0; i < len; i++) send_bit(s[i]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.serial_in = 1'b0;
        model_reset();
        #2;
        check("reset_outputs",
              32'({bus.word_out, bus.is_comma, bus.word_valid, bus.locked, bus.realign_cnt}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step_n = 0; first_valid = 0; lock_rise = 0; prev_locked = 1'b0;
    endtask

    task automatic lock_stream();
        send_sym(K28N, 10); send_sym(D215, 10);
        send_sym(K28N, 10); send_sym(D215, 10);
        send_sym(K28N, 10); send_sym(D215, 10);
    endtask

    initial begin
        bus.serial_in = 1'b0;
        model_reset();

        // Basic lock: first word 1 clk after first j bit, lock on third comma.
        apply_reset();
        lock_stream();
        check("first_valid_clk", first_valid, 11);
        check("lock_rise_clk", lock_rise, 51);
        check("realign_after_lock", bus.realign_cnt, 1);

        // Same stream behind 3 random bits: everything shifted by 3 clks.
        apply_reset();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        send_sym(K28N, 10); send_sym(D215, 10);
        send_sym(K28N, 10); send_sym(D215, 10);
        send_sym(K28N, 10); send_sym(D215, 10);
        check("first_valid_phase3", first_valid, 14);
        check("lock_rise_phase3", lock_rise, 54);

        // Cumulative 1-bit slips: four misaligned commas drop lock.
        for (int g = 0; g < 4; g++) begin
            send_bit(1'b1);
            send_sym(K28N, 10);
            send_sym(D215, 10);
            check("slip_locked", bus.locked, (g < 3) ? 1 : 0);
            for (int k = 0; k < 8; k++) send_sym(D215, 10);
        end
        send_sym(K28N, 10); send_sym(D215, 10);
        check("slip_relock_realign", bus.realign_cnt, 2);
        check("slip_relock_state", bus.locked, 0);

        // Three misses then an aligned comma: lock holds and miss count clears.
        apply_reset();
        lock_stream();
        unlock_cycles = 0; max_gap = 0;
        for (int r = 0; r < 2; r++) begin
            for (int g = 0; g < 3; g++) begin
                send_bit(1'b1); send_sym(K28N, 10); send_sym(D215, 9);
            end
            send_sym(D215, 10); send_sym(K28N, 10); send_sym(D215, 10);
        end
        check("miss_unlock_cycles", unlock_cycles, 0);
        check("miss_valid_gap", max_gap, 10);
        check("miss_locked_end", bus.locked, 1);

        // Idle zeros never align; then an async reset while locked.
        apply_reset();
        valid_cnt = 0;
        for (int i = 0; i < 1000; i++) send_bit(1'b0);
        check("zeros_valid_cnt", valid_cnt, 0);
        check("zeros_realign", bus.realign_cnt, 0);
        lock_stream();
        check("locked_before_rst", bus.locked, 1);
        apply_reset();
        send_sym(K28N, 10); send_sym(D215, 10);
        send_sym(K28N, 10); send_sym(D215, 10);
        check("fresh_two_commas", bus.locked, 0);
        send_sym(K28N, 10); send_sym(D215, 10);
        check("fresh_three_commas", bus.locked, 1);

        // Random mix of commas, data and odd-length bit runs.
        apply_reset();
        for (int t = 0; t < 150; t++) begin
            int sel = int'($urandom_range(0, 7));
            if (sel < 3) send_sym(K28N, 10);
            else if (sel < 4) send_sym(K28P, 10);
            else if (sel < 6) send_sym(D215, 10);
            else begin
                int len = int'($urandom_range(1, 12));
                for (int i = 0; i < len; i++) send_bit(1'($urandom));
            end
        end

        // Every comma 11 bits apart realigns: counter must stop at 255.
        apply_reset();
        for (int c = 0; c < 262; c++) begin
            send_sym(K28N, 10);
            send_bit(1'b1);
        end
        check("realign_saturate", bus.realign_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_comma_aligner.md
RX_COMMA_ALIGNER -- requirements
Module: rx_comma_aligner

Interface
REQ-001 SHALL provide parameter LOCK_COMMAS, default 3: consecutive aligned commas to declare lock (legal 1..15).
REQ-002 SHALL provide parameter UNLOCK_MISS, default 4: consecutive misaligned commas in LOCKED that force SEARCH (legal 1..15).
REQ-003 SHALL provide port clk  input  1: bit clock, one serial bit per rising edge.
REQ-004 SHALL provide port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL provide port serial_in  input  1: recovered serial bit from the PHY channel model, 8b/10b encoded, bit 'a' first.
REQ-006 SHALL provide port word_out  output  10: aligned 10-bit symbol, word_out[0]=bit a ... word_out[9]=bit j.
REQ-007 SHALL provide port word_valid  output  1: one-cycle pulse qualifying word_out.
REQ-008 SHALL provide port is_comma  output  1: word_out is K28.5 (either disparity), qualified by word_valid.
REQ-009 SHALL provide port locked  output  1: high while the FSM is in LOCKED.
REQ-010 SHALL provide port realign_cnt  output  8: saturating count of alignment changes.

Function
REQ-011 SHALL shift serial_in into a 10-bit window every clk; after each edge, window[0] is the oldest bit and window[9] is the newest.
REQ-012 SHALL flag comma when window (a..j order) equals 0011111010 (RD-) or 1100000101 (RD+), evaluated on the registered window.
REQ-013 SHALL keep a 4-bit slot counter 0..9 that wraps 9->0; the window is "aligned" when slot==9.
REQ-014 SHALL implement FSM states SEARCH, CHECK, LOCKED; reset state SEARCH.
REQ-015 SEARCH: on comma, set slot so the current window is aligned, good_cnt=1, realign_cnt+1, go to CHECK (or directly LOCKED if LOCK_COMMAS==1).
REQ-016 CHECK: aligned comma -> good_cnt+1; on reaching LOCK_COMMAS go to LOCKED.
REQ-017 CHECK: comma at a misaligned slot -> realign to it, good_cnt=1, realign_cnt+1, stay in CHECK.
REQ-018 LOCKED: misaligned comma -> miss_cnt+1, alignment unchanged; aligned comma -> miss_cnt=0; miss_cnt reaching UNLOCK_MISS -> SEARCH, miss_cnt=0.
REQ-019 Non-comma data in any state SHALL NOT change state, good_cnt or miss_cnt.
REQ-020 In CHECK and LOCKED, every aligned window SHALL be registered to word_out with word_valid=1 and is_comma=comma on the next edge (latency 1 clk after the j bit is sampled).
REQ-021 In SEARCH, word_valid SHALL be 0 and word_out SHALL hold its last value.
REQ-022 A realigning comma (REQ-015/017) SHALL itself be emitted as a valid word; the partial word of the old alignment is discarded.
REQ-023 realign_cnt SHALL saturate at 255 and never wrap.
REQ-024 locked SHALL be registered; it rises on the edge that enters LOCKED and falls on the edge that leaves it.

Reset
REQ-025 rst_n low SHALL immediately clear window, slot, good_cnt, miss_cnt, word_out=0, word_valid=0, is_comma=0, locked=0, realign_cnt=0, state=SEARCH.
REQ-026 Reset asserted mid-word or in LOCKED SHALL discard all alignment; after release, lock needs LOCK_COMMAS fresh commas.

Verification
REQ-027 After reset, send K28.5- then D21.5 then K28.5- (x3 total, 10-bit spacing) -> first word_valid 1 clk after the first comma's j bit; locked rises with the third comma; realign_cnt=1.
REQ-028 Prepend 3 random bits (arbitrary phase) to REQ-027's stream -> identical word sequence and lock, delayed by 3 clks.
REQ-029 Once locked, insert a 1-bit slip every 10th symbol starting with a comma for 4 commas -> locked falls after the 4th misaligned comma; the next comma re-enters CHECK; realign_cnt=2.
REQ-030 Once locked, send 3 misaligned commas then 1 aligned comma -> locked stays 1, miss_cnt cleared; no word_valid gap.
REQ-031 All-zeros input for 1000 clks -> stays SEARCH, word_valid never 1, realign_cnt=0; then pulse rst_n mid-LOCKED -> all outputs 0 asynchronously.
